tank_draw_scheduler: RTL and testbench
======================================

# tank_draw_scheduler

Sequences and shares the single tank-sprite draw engine (60-pixel, 9x9 footprint, direction-selected) between several requesters, typically the player tanks. Each request erases the requester's previously drawn sprite in background colour, then draws it at the new position, direction and colour. It drives the engine's position, direction and counter enable, and the VGA adapter's plot strobe and colour. It sits between the game-logic FSMs and the draw engine / VGA adapter.

## Interface
- NUM_REQ, 2: number of requesters (2..4)
- COLOR_W, 3: colour width
- BG_COLOR, 0: erase colour
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- req  in  NUM_REQ  per-requester request, level; held until ack
- req_op  in  NUM_REQ  per-requester op: 0 = move (erase old, draw new), 1 = remove (erase only)
- req_xpos  in  8*NUM_REQ  new sprite x origin, requester i at bits [8i+7:8i]
- req_ypos  in  7*NUM_REQ  new sprite y origin
- req_dir  in  2*NUM_REQ  new direction (0 up, 1 down, 2 left, 3 right)
- req_color  in  COLOR_W*NUM_REQ  sprite colour
- ack  out  NUM_REQ  one-cycle completion pulse to the granted requester
- busy  out  1  high whenever state is not IDLE
- eng_xpos  out  8  engine x origin
- eng_ypos  out  7  engine y origin
- eng_dir  out  2  engine direction
- eng_enable  out  1  engine counter_enable
- eng_finish  in  1  engine finish (high while the engine is on pixel 59)
- plot  out  1  VGA write enable; identical to eng_enable
- color  out  COLOR_W  VGA pixel colour

## Operation
- States: IDLE, ERASE, DRAW, DONE.
- Per-requester shadow registers hold last drawn x, y, dir and a valid bit.
- IDLE: if any req, a round-robin arbiter picks winner w, starting from pointer p. Snapshot of req_op, xpos, ypos, dir and color for w is latched.
  - If valid[w] = 1, next state is ERASE.
  - Else if op = move, next state is DRAW.
  - Else next state is DONE.
  - Pointer update: p <= (w+1) mod NUM_REQ.
- ERASE:
  - eng_enable = plot = 1.
  - eng_xpos/ypos/dir come from the shadow of w; color = BG_COLOR.
  - On eng_finish: op = move goes to DRAW, op = remove goes to DONE.
- DRAW:
  - eng_enable = plot = 1.
  - eng_xpos/ypos/dir/color come from the latched snapshot.
  - On eng_finish, go to DONE.
- DONE: ack[w] = 1 and return to IDLE.
  - Shadow update: move sets shadow[w] to the snapshot with valid[w] = 1; remove clears valid[w].
- Outside ERASE/DRAW: eng_enable = plot = 0, which returns the engine counter to 0.
- Request inputs are sampled only in IDLE. Changes during service are ignored.
- Reset:
  - state = IDLE, p = 0, all valid = 0.
  - ack = 0, busy = 0, eng_enable = plot = 0.
  - eng_xpos = eng_ypos = eng_dir = 0, color = 0.
  - Reset mid-operation abandons the sprite; pixels already written stay on screen.

## Timing
- Let t be the IDLE cycle in which req is sampled high.
- Move with valid shadow: ERASE t+1..t+60, DRAW t+61..t+120, ack at t+121, IDLE at t+122.
- Move with no valid shadow (first draw): DRAW t+1..t+60, ack at t+61.
- Remove with valid shadow: ERASE t+1..t+60, ack at t+61.
- Remove with no valid shadow: ack at t+1, no plot cycles.
- The transition out of ERASE/DRAW is the edge ending the eng_finish cycle, so pixel 59 is plotted.
- There is no idle gap between ERASE and DRAW.
- ack, busy, eng_xpos, eng_ypos, eng_dir and color are registered/state-decoded with no input-to-output combinational path. plot/eng_enable decode from state only.
- Requester handshake: the requester drops req on the edge where it samples ack = 1. The following IDLE cycle therefore sees the updated req.
- Simultaneous requests are served one per transaction in round-robin order. No requester waits more than NUM_REQ-1 transactions.

## Configuration
- TANK_DRAW_SCHED_ERASE_EN defined: full behaviour as above.
- Undefined:
  - ERASE state, shadow registers and valid bits are removed.
  - Move always goes straight to DRAW: ack at t+61.
  - Remove acks at t+1 without plotting.

## Structure
- Shared package draw_sched_pkg holds:
  - state enum (IDLE, ERASE, DRAW, DONE)
  - SPRITE_PIXELS = 60
  - direction constants DIR_UP/DOWN/LEFT/RIGHT
  - op constants OP_MOVE/OP_REMOVE
- Sub-module rr_arbiter (NUM_REQ, req vector, pointer in) produces a one-hot grant and a binary index.
- The bench models the draw engine: finish on the 60th consecutive enable cycle, counter cleared when enable is low.

## Test plan
- First move, req[0] at (20,30) dir 0 colour 3'b100 -> 60 plot cycles at colour 4, eng_xpos 20 / eng_ypos 30; ack[0] at t+61.
- Second move of req[0] to (21,30) dir 3 -> 60 plots at BG_COLOR with origin (20,30) dir 0, then 60 plots at (21,30) dir 3; ack at t+121.
- req[0] and req[1] raised in the same cycle after reset -> requester 0 served first, then requester 1 with no starvation; repeat shows alternation from pointer p.
- Remove on valid requester 1 -> 60 BG plots at its last position, ack at t+61, valid cleared; a second remove acks at t+1 with zero plots.
- Reset asserted mid-DRAW -> plot/eng_enable/busy low immediately; after release, the next move from that requester performs no erase.
- Build with TANK_DRAW_SCHED_ERASE_EN undefined -> repeated moves each give exactly 60 plot cycles and ack at t+61.

Source files
------------

// File: rtl/draw_sched_pkg.sv
// draw_sched_pkg: shared states, sprite constants and position record for the tank draw scheduler
package draw_sched_pkg;
  typedef enum logic [1:0] {IDLE, ERASE, DRAW, DONE} state_t;
  localparam int SPRITE_PIXELS = 60;
  localparam logic [1:0] DIR_UP = 2'd0, DIR_DOWN = 2'd1, DIR_LEFT = 2'd2, DIR_RIGHT = 2'd3;
  localparam logic OP_MOVE = 1'b0, OP_REMOVE = 1'b1;
  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [1:0] dir;
  } pos_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: picks the first requester at or after ptr, as one-hot grant and binary index
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IW = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IW-1:0]      idx,
  output logic               any
);
  always_comb begin
    grant = '0;
    idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req[(int'(ptr) + k) % NUM_REQ]) begin
        grant = '0;
        grant[(int'(ptr) + k) % NUM_REQ] = 1'b1;
        idx = IW'((int'(ptr) + k) % NUM_REQ);
      end
    end
  end
  assign any = |req;
endmodule

// File: rtl/tank_draw_scheduler.sv
// tank_draw_scheduler: shares one tank-sprite draw engine between requesters (erase-before-draw when TANK_DRAW_SCHED_ERASE_EN is defined)
module tank_draw_scheduler
  import draw_sched_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int COLOR_W = 3,
  parameter logic [COLOR_W-1:0] BG_COLOR = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ-1:0]         req_op,
  input  logic [8*NUM_REQ-1:0]       req_xpos,
  input  logic [7*NUM_REQ-1:0]       req_ypos,
  input  logic [2*NUM_REQ-1:0]       req_dir,
  input  logic [COLOR_W*NUM_REQ-1:0] req_color,
  output logic [NUM_REQ-1:0]         ack,
  output logic                       busy,
  output logic [7:0]                 eng_xpos,
  output logic [6:0]                 eng_ypos,
  output logic [1:0]                 eng_dir,
  output logic                       eng_enable,
  input  logic                       eng_finish,
  output logic                       plot,
  output logic [COLOR_W-1:0]         color
);
  localparam int IW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
  state_t state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic op_q, op_d;
  pos_t snap_q, snap_d, eng_pos;
  logic [COLOR_W-1:0] col_q, col_d;
  logic [NUM_REQ-1:0] grant;
  logic [IW-1:0] idx;
  logic any;
`ifdef TANK_DRAW_SCHED_ERASE_EN
  logic [IW-1:0] w_q, w_d;
  pos_t [NUM_REQ-1:0] sh_q, sh_d;
  logic [NUM_REQ-1:0] vld_q, vld_d;
`endif
  rr_arbiter #(.NUM_REQ(NUM_REQ), .IW(IW)) u_arb (
    .req(req), .ptr(ptr_q), .grant(grant), .idx(idx), .any(any)
  );
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    gnt_d = gnt_q;
    op_d = op_q;
    snap_d = snap_q;
    col_d = col_q;
`ifdef TANK_DRAW_SCHED_ERASE_EN
    w_d = w_q;
    sh_d = sh_q;
    vld_d = vld_q;
`endif
    case (state_q)
      IDLE: if (any) begin
        gnt_d = grant;
        op_d = req_op[idx];
        snap_d = '{x: req_xpos[8*int'(idx) +: 8], y: req_ypos[7*int'(idx) +: 7], dir: req_dir[2*int'(idx) +: 2]};
        col_d = req_color[COLOR_W*int'(idx) +: COLOR_W];
        ptr_d = (idx == IW'(NUM_REQ - 1)) ? '0 : idx + 1'b1;
`ifdef TANK_DRAW_SCHED_ERASE_EN
        w_d = idx;
        state_d = vld_q[idx] ? ERASE : (req_op[idx] == OP_MOVE ? DRAW : DONE);
`else
        state_d = req_op[idx] == OP_MOVE ? DRAW : DONE;
`endif
      end
      ERASE: if (eng_finish) state_d = op_q == OP_MOVE ? DRAW : DONE;
      DRAW: if (eng_finish) state_d = DONE;
      default: begin
        state_d = IDLE;
`ifdef TANK_DRAW_SCHED_ERASE_EN
        if (op_q == OP_MOVE) sh_d[w_q] = snap_q;
        vld_d[w_q] = op_q == OP_MOVE;
`endif
      end
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q <= '0;
      gnt_q <= '0;
      op_q <= OP_MOVE;
      snap_q <= '0;
      col_q <= '0;
`ifdef TANK_DRAW_SCHED_ERASE_EN
      w_q <= '0;
      sh_q <= '0;
      vld_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      gnt_q <= gnt_d;
      op_q <= op_d;
      snap_q <= snap_d;
      col_q <= col_d;
`ifdef TANK_DRAW_SCHED_ERASE_EN
      w_q <= w_d;
      sh_q <= sh_d;
      vld_q <= vld_d;
`endif
    end
  end
  assign busy = state_q != IDLE;
  assign eng_enable = state_q == ERASE || state_q == DRAW;
  assign plot = eng_enable;
  assign ack = state_q == DONE ? gnt_q : '0;
`ifdef TANK_DRAW_SCHED_ERASE_EN
  assign eng_pos = state_q == ERASE ? sh_q[w_q] : snap_q;
  assign color = state_q == ERASE ? BG_COLOR : col_q;
`else
  assign eng_pos = snap_q;
  assign color = col_q;
`endif
  assign eng_xpos = eng_pos.x;
  assign eng_ypos = eng_pos.y;
  assign eng_dir = eng_pos.dir;
endmodule

// File: tb/tb_tank_draw_scheduler.sv
// tb_tank_draw_scheduler: table-driven check of the draw scheduler against a 60-pixel engine model
module tb_tank_draw_scheduler;
`ifdef TANK_DRAW_SCHED_ERASE_EN
  localparam bit EE = 1'b1;
`else
  localparam bit EE = 1'b0;
`endif
  logic clk = 1'b0, reset;
  logic [1:0] req, req_op, ack, eng_dir;
  logic [15:0] req_xpos;
  logic [13:0] req_ypos;
  logic [3:0] req_dir;
  logic [5:0] req_color;
  logic busy, eng_enable, eng_finish, plot;
  logic [7:0] eng_xpos;
  logic [6:0] eng_ypos;
  logic [2:0] color;
  int cnt;
  int checks = 0, errors = 0;

  typedef struct {
    int r, op, x, y, dir, col;
    int e_ack, e_plots, e_bg;
    int fx, fy, fd;
    int lx, ly, ld, lc;
  } vec_t;
  vec_t v[6];

  tank_draw_scheduler #(.NUM_REQ(2), .COLOR_W(3), .BG_COLOR(3'd0)) dut (
    .clk(clk), .reset(reset), .req(req), .req_op(req_op), .req_xpos(req_xpos),
    .req_ypos(req_ypos), .req_dir(req_dir), .req_color(req_color), .ack(ack),
    .busy(busy), .eng_xpos(eng_xpos), .eng_ypos(eng_ypos), .eng_dir(eng_dir),
    .eng_enable(eng_enable), .eng_finish(eng_finish), .plot(plot), .color(color)
  );

  always #5 clk = ~clk;

  always @(posedge clk or posedge reset)
    if (reset) cnt <= 0;
    else cnt <= (!eng_enable || cnt == 59) ? 0 : cnt + 1;
  assign eng_finish = eng_enable && cnt == 59;

  task automatic chk(input string n, input int a, input int e);
    checks++;
    if (a != e) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", n, a, e);
    end
  endtask

  task automatic set_req(input int r, input int op, input int x, input int y, input int d, input int c);
    req_op[r] = op[0];
    req_xpos[8*r +: 8] = x[7:0];
    req_ypos[7*r +: 7] = y[6:0];
    req_dir[2*r +: 2] = d[1:0];
    req_color[3*r +: 3] = c[2:0];
    req[r] = 1'b1;
  endtask

  task automatic run_txn(input int r, input int op, input int x, input int y, input int d, input int c,
                         output int ack_cyc, output int ackv, output int plots, output int bgp,
                         output int fx, output int fy, output int fd,
                         output int lx, output int ly, output int ld, output int lc);
    ack_cyc = -1; ackv = 0; plots = 0; bgp = 0;
    fx = -1; fy = -1; fd = -1; lx = -1; ly = -1; ld = -1; lc = -1;
    @(negedge clk);
    set_req(r, op, x, y, d, c);
    for (int k = 1; k <= 300; k++) begin
      @(negedge clk);
      if (plot) begin
        if (plots == 0) begin fx = eng_xpos; fy = eng_ypos; fd = eng_dir; end
        plots++;
        if (color == 3'd0) bgp++;
        lx = eng_xpos; ly = eng_ypos; ld = eng_dir; lc = color;
      end
      if (ack != 2'b00) begin
        ack_cyc = k; ackv = ack; req[r] = 1'b0;
        break;
      end
    end
    req[r] = 1'b0;
  endtask

  task automatic serve_both(output int a1, output int a2, output int c1, output int c2);
    int n;
    n = 0; a1 = 0; a2 = 0; c1 = -1; c2 = -1;
    @(negedge clk);
    set_req(0, 0, 30, 40, 1, 2);
    set_req(1, 0, 70, 50, 0, 3);
    for (int k = 1; k <= 600 && n < 2; k++) begin
      @(negedge clk);
      if (ack != 2'b00) begin
        if (n == 0) begin a1 = ack; c1 = k; end
        else begin a2 = ack; c2 = k; end
        n++;
        req = req & ~ack;
      end
    end
    req = 2'b00;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    req = 2'b00;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int ac, av, pl, bg, fx, fy, fd, lx, ly, ld, lc, a1, a2, c1, c2;
    v[0] = '{0, 0, 20, 30, 0, 4, 61, 60, 0, 20, 30, 0, 20, 30, 0, 4};
    v[1] = '{0, 0, 21, 30, 3, 4, EE ? 121 : 61, EE ? 120 : 60, EE ? 60 : 0,
             EE ? 20 : 21, 30, EE ? 0 : 3, 21, 30, 3, 4};
    v[2] = '{1, 0, 50, 10, 2, 5, 61, 60, 0, 50, 10, 2, 50, 10, 2, 5};
    v[3] = '{1, 1, 50, 10, 2, 5, EE ? 61 : 1, EE ? 60 : 0, EE ? 60 : 0, 50, 10, 2, 50, 10, 2, 0};
    v[4] = '{1, 1, 50, 10, 2, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    v[5] = '{1, 0, 60, 20, 1, 6, 61, 60, 0, 60, 20, 1, 60, 20, 1, 6};
    reset = 1'b1;
    req = '0; req_op = '0; req_xpos = '0; req_ypos = '0; req_dir = '0; req_color = '0;
    repeat (2) @(negedge clk);
    chk("rst_ack", ack, 0);
    chk("rst_busy", busy, 0);
    chk("rst_plot", plot, 0);
    chk("rst_enable", eng_enable, 0);
    chk("rst_xpos", eng_xpos, 0);
    chk("rst_ypos", eng_ypos, 0);
    chk("rst_dir", eng_dir, 0);
    chk("rst_color", color, 0);
    reset = 1'b0;

    for (int i = 0; i < 6; i++) begin
      run_txn(v[i].r, v[i].op, v[i].x, v[i].y, v[i].dir, v[i].col, ac, av, pl, bg, fx, fy, fd, lx, ly, ld, lc);
      chk($sformatf("v%0d_ack_cycle", i), ac, v[i].e_ack);
      chk($sformatf("v%0d_ack_vec", i), av, 1 << v[i].r);
      chk($sformatf("v%0d_plots", i), pl, v[i].e_plots);
      chk($sformatf("v%0d_bg_plots", i), bg, v[i].e_bg);
      if (v[i].e_plots > 0) begin
        chk($sformatf("v%0d_first_x", i), fx, v[i].fx);
        chk($sformatf("v%0d_first_y", i), fy, v[i].fy);
        chk($sformatf("v%0d_first_dir", i), fd, v[i].fd);
        chk($sformatf("v%0d_last_x", i), lx, v[i].lx);
        chk($sformatf("v%0d_last_y", i), ly, v[i].ly);
        chk($sformatf("v%0d_last_dir", i), ld, v[i].ld);
        chk($sformatf("v%0d_last_color", i), lc, v[i].lc);
      end
    end

    // simultaneous requests: pointer starts at 0 after reset
    do_reset();
    serve_both(a1, a2, c1, c2);
    chk("both1_first", a1, 1);
    chk("both1_second", a2, 2);
    chk("both1_first_cycle", c1, 61);
    chk("both1_second_cycle", c2, 123);
    serve_both(a1, a2, c1, c2);
    chk("both2_first", a1, 1);
    chk("both2_second", a2, 2);
    run_txn(0, 0, 5, 5, 0, 1, ac, av, pl, bg, fx, fy, fd, lx, ly, ld, lc);
    chk("solo_ack_vec", av, 1);
    serve_both(a1, a2, c1, c2);
    chk("both3_first", a1, 2);
    chk("both3_second", a2, 1);

    // reset while drawing, then the next move must not erase
    do_reset();
    run_txn(0, 0, 40, 40, 2, 7, ac, av, pl, bg, fx, fy, fd, lx, ly, ld, lc);
    chk("pre_ack_cycle", ac, 61);
    @(negedge clk);
    set_req(0, 0, 41, 40, 2, 5);
    ac = -1;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      if (plot && color == 3'd5) begin ac = k; break; end
    end
    chk("mid_draw_reached", ac >= 0 ? 1 : 0, 1);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    req = 2'b00;
    #1;
    chk("mid_rst_plot", plot, 0);
    chk("mid_rst_enable", eng_enable, 0);
    chk("mid_rst_busy", busy, 0);
    @(negedge clk);
    reset = 1'b0;
    run_txn(0, 0, 42, 40, 1, 6, ac, av, pl, bg, fx, fy, fd, lx, ly, ld, lc);
    chk("post_rst_ack_cycle", ac, 61);
    chk("post_rst_plots", pl, 60);
    chk("post_rst_bg_plots", bg, 0);
    chk("post_rst_x", lx, 42);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
